// File: rtl/console_pkg.sv
// Shared register map and STATUS/CTRL field positions for the MMIO debug console.
// Other console files pull these in with a package import.
package console_pkg;

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_CNT_LSB = 8;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_FLUSH = 1;

  function automatic logic [31:0] pack_status(input logic full, input logic empty,
                                              input logic ovf, input logic [7:0] cnt);
    logic [31:0] w;
    w = 32'h0000_0000;
    w[STAT_FULL]             = full;
    w[STAT_EMPTY]            = empty;
    w[STAT_OVF]              = ovf;
    w[STAT_CNT_LSB +: 8]     = cnt;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous flush.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           flush,
  input  logic [WIDTH-1:0]               wr_data,
  output logic [WIDTH-1:0]               head,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_s;
  logic             empty_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_s    = (count_r == CNT_FULL);
  assign empty_s   = (count_r == CNT_ZERO);
  assign do_pop_s  = pop & ~empty_s;
  assign do_push_s = push & (~full_s | do_pop_s);

  assign head  = mem_r[rd_ptr_r];
  assign full  = full_s;
  assign empty = empty_s;
  assign count = count_r;

  // Pointer and occupancy tracking; flush takes priority over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else if (flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array write port; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push_s & ~flush) mem_r[wr_ptr_r] <= wr_data;
  end

endmodule

// File: rtl/mmio_console.sv
// Memory-mapped debug console: CPU stores to TXDATA are queued and drained as a
// paced valid/ready byte stream; STATUS and CTRL are readable on the same port.
module mmio_console
  import console_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          DEPTH       = 16,
  parameter int          CHAR_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wenable,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (CHAR_CYCLES > 0) ? $clog2(CHAR_CYCLES + 1) : 1;
  localparam logic [PW-1:0] PACE_LOAD = PW'(CHAR_CYCLES);
  localparam logic [PW-1:0] PACE_ONE  = PW'(1);
  localparam logic [PW-1:0] PACE_ZERO = PW'(0);

  logic          hit_s;
  logic [3:0]    off_s;
  logic          push_s;
  logic          status_wr_s;
  logic          ctrl_wr_s;
  logic          flush_s;
  logic          fire_s;
  logic          full_s;
  logic          empty_s;
  logic [CW-1:0] count_s;
  logic [7:0]    count8_s;
  logic [7:0]    head_s;
  logic          enable_r;
  logic          overflow_r;
  logic [PW-1:0] pace_cnt_r;
  logic          unused_s;

  assign hit_s = (addr[31:4] == BASE_ADDR[31:4]);
  assign off_s = addr[3:0];

  // Bus write decode; only byte lane 0 carries register fields.
  always_comb begin
    push_s      = 1'b0;
    status_wr_s = 1'b0;
    ctrl_wr_s   = 1'b0;
    if (hit_s & wenable[0]) begin
      case (off_s)
        OFF_TXDATA: push_s      = 1'b1;
        OFF_STATUS: status_wr_s = 1'b1;
        OFF_CTRL:   ctrl_wr_s   = 1'b1;
        default:    push_s      = 1'b0;
      endcase
    end else begin
      push_s = 1'b0;
    end
  end

  assign flush_s  = ctrl_wr_s & wdata[CTRL_FLUSH];
  assign tx_valid = ~empty_s & enable_r & (pace_cnt_r == PACE_ZERO);
  assign tx_data  = head_s;
  assign fire_s   = tx_valid & tx_ready;
  assign unused_s = ^{wdata[31:8], wenable[3:1]};

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_s),
    .pop     (fire_s),
    .flush   (flush_s),
    .wr_data (wdata[7:0]),
    .head    (head_s),
    .full    (full_s),
    .empty   (empty_s),
    .count   (count_s)
  );

  generate
    if (CW >= 8) begin : g_cnt_trunc
      assign count8_s = count_s[7:0];
    end else begin : g_cnt_ext
      assign count8_s = {{(8 - CW){1'b0}}, count_s};
    end
  endgenerate

  // CTRL enable bit; flush is a pulse and is never stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            enable_r <= 1'b1;
    else if (ctrl_wr_s) enable_r <= wdata[CTRL_EN];
    else                enable_r <= enable_r;
  end

  // Sticky overflow: a drop while full sets it, a STATUS write of bit 2 clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       overflow_r <= 1'b0;
    else if (push_s & full_s & ~fire_s & ~flush_s) overflow_r <= 1'b1;
    else if (status_wr_s & wdata[STAT_OVF])        overflow_r <= 1'b0;
    else                                           overflow_r <= overflow_r;
  end

  // Pacing counter holds tx_valid low for CHAR_CYCLES cycles after each transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          pace_cnt_r <= PACE_ZERO;
    else if (flush_s)                 pace_cnt_r <= PACE_ZERO;
    else if (fire_s)                  pace_cnt_r <= PACE_LOAD;
    else if (pace_cnt_r != PACE_ZERO) pace_cnt_r <= pace_cnt_r - PACE_ONE;
    else                              pace_cnt_r <= pace_cnt_r;
  end

  // Read mux; misses and unmapped offsets return zero.
  always_comb begin
    rdata = 32'h0000_0000;
    if (hit_s) begin
      case (off_s)
        OFF_STATUS: rdata = pack_status(full_s, empty_s, overflow_r, count8_s);
        OFF_CTRL:   rdata[CTRL_EN] = enable_r;
        default:    rdata = 32'h0000_0000;
      endcase
    end else begin
      rdata = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_mmio_console.sv
// Directed bench for mmio_console: a vector table for single-cycle register
// behaviour plus hand-written sequences for FIFO, pacing, flush and reset cases.
module tb_mmio_console;

  localparam logic [31:0] A_TX = 32'h1000_0000;
  localparam logic [31:0] A_ST = 32'h1000_0004;
  localparam logic [31:0] A_CT = 32'h1000_0008;
  localparam int NV = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wenable;
  logic        tx_ready;
  logic        tx_ready_p;
  logic [31:0] rdata, rdata_p;
  logic [7:0]  tx_data, tx_data_p;
  logic        tx_valid, tx_valid_p;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        rdy;
    logic [31:0] exp_rdata;
    logic        exp_valid;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs [NV];
  int   fire_cyc [$];
  logic [7:0] fire_dat [$];

  always #5 clk = ~clk;

  mmio_console dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wenable(wenable),
    .rdata(rdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  mmio_console #(.CHAR_CYCLES(3)) dut_p (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wenable(wenable),
    .rdata(rdata_p), .tx_data(tx_data_p), .tx_valid(tx_valid_p), .tx_ready(tx_ready_p)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we,
                       input logic rdy);
    @(negedge clk);
    addr = a; wdata = d; wenable = we; tx_ready = rdy;
    #1;
  endtask

  task automatic store(input logic [7:0] b, input logic rdy);
    drive(A_TX, {24'h0, b}, 4'h1, rdy);
  endtask

  task automatic nop(input logic rdy);
    drive(32'h0, 32'h0, 4'h0, rdy);
  endtask

  initial begin
    vecs[0]  = '{A_ST,          32'h0,  4'h0, 1'b1, 32'h0000_0002, 1'b0, 8'h00};
    vecs[1]  = '{A_TX,          32'h48, 4'h1, 1'b1, 32'h0000_0000, 1'b0, 8'h00};
    vecs[2]  = '{A_TX,          32'h69, 4'h1, 1'b1, 32'h0000_0000, 1'b1, 8'h48};
    vecs[3]  = '{A_ST,          32'h0,  4'h0, 1'b1, 32'h0000_0100, 1'b1, 8'h69};
    vecs[4]  = '{A_ST,          32'h0,  4'h0, 1'b1, 32'h0000_0002, 1'b0, 8'h00};
    vecs[5]  = '{A_CT,          32'h0,  4'h0, 1'b1, 32'h0000_0001, 1'b0, 8'h00};
    vecs[6]  = '{32'h1000_000C, 32'h0,  4'h0, 1'b1, 32'h0000_0000, 1'b0, 8'h00};
    vecs[7]  = '{32'h1000_0002, 32'h0,  4'h0, 1'b1, 32'h0000_0000, 1'b0, 8'h00};
    vecs[8]  = '{32'h2000_0004, 32'h0,  4'h0, 1'b1, 32'h0000_0000, 1'b0, 8'h00};
    vecs[9]  = '{32'h2000_0000, 32'h41, 4'h1, 1'b1, 32'h0000_0000, 1'b0, 8'h00};
    vecs[10] = '{A_ST,          32'h0,  4'h0, 1'b1, 32'h0000_0002, 1'b0, 8'h00};
    vecs[11] = '{A_TX,          32'h42, 4'he, 1'b1, 32'h0000_0000, 1'b0, 8'h00};
    vecs[12] = '{A_ST,          32'h0,  4'h0, 1'b1, 32'h0000_0002, 1'b0, 8'h00};
    vecs[13] = '{32'h1000_0001, 32'h43, 4'h1, 1'b1, 32'h0000_0000, 1'b0, 8'h00};
    vecs[14] = '{A_ST,          32'h0,  4'h0, 1'b1, 32'h0000_0002, 1'b0, 8'h00};

    rst = 1'b1; addr = 32'h0; wdata = 32'h0; wenable = 4'h0;
    tx_ready = 1'b0; tx_ready_p = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
    rst = 1'b0;

    // Register/table phase (includes the 0x48, 0x69 back-to-back print)
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].rdy);
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_valid", i), {31'h0, tx_valid}, {31'h0, vecs[i].exp_valid});
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d_data", i), {24'h0, tx_data}, {24'h0, vecs[i].exp_data});
    end

    // Overflow: DEPTH+1 stores with sink stalled
    for (int i = 0; i < 16; i++) store(8'h10 + 8'(i), 1'b0);
    drive(A_ST, 32'h0, 4'h0, 1'b0);
    check("full_status", rdata, 32'h0000_1001);
    check("stall_head", {24'h0, tx_data}, 32'h10);
    store(8'h20, 1'b0);
    drive(A_ST, 32'h0, 4'h0, 1'b0);
    check("ovf_status", rdata, 32'h0000_1005);
    for (int i = 0; i < 16; i++) begin
      nop(1'b1);
      check($sformatf("drain%0d", i), {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'h10 + 8'(i)});
    end
    drive(A_ST, 32'h0, 4'h0, 1'b1);
    check("extra_absent", {31'h0, tx_valid}, 32'h0);
    check("drained_status", rdata, 32'h0000_0006);
    drive(A_ST, 32'h4, 4'h1, 1'b1);
    drive(A_ST, 32'h0, 4'h0, 1'b1);
    check("ovf_cleared", rdata, 32'h0000_0002);

    // Full FIFO with a same-cycle pop and push
    for (int i = 0; i < 16; i++) store(8'h80 + 8'(i), 1'b0);
    drive(A_ST, 32'h0, 4'h0, 1'b0);
    check("refill_status", rdata, 32'h0000_1001);
    store(8'hEE, 1'b1);
    check("popfull_head", {24'h0, tx_data}, 32'h80);
    drive(A_ST, 32'h0, 4'h0, 1'b0);
    check("pushpop_status", rdata, 32'h0000_1001);
    for (int i = 0; i < 16; i++) begin
      nop(1'b1);
      check($sformatf("drain2_%0d", i), {23'h0, tx_valid, tx_data},
            {23'h0, 1'b1, (i == 15) ? 8'hEE : 8'h81 + 8'(i)});
    end
    nop(1'b1);
    check("drain2_end", {31'h0, tx_valid}, 32'h0);

    // Disable, re-enable, flush
    drive(A_CT, 32'h0, 4'h1, 1'b1);
    store(8'hA1, 1'b1);
    store(8'hA2, 1'b1);
    drive(A_ST, 32'h0, 4'h0, 1'b1);
    check("dis_status", rdata, 32'h0000_0200);
    check("dis_valid", {31'h0, tx_valid}, 32'h0);
    drive(A_CT, 32'h0, 4'h0, 1'b1);
    check("dis_ctrl", rdata, 32'h0);
    drive(A_CT, 32'h1, 4'h1, 1'b1);
    check("enwr_valid", {31'h0, tx_valid}, 32'h0);
    nop(1'b1);
    check("en_a1", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'hA1});
    nop(1'b1);
    check("en_a2", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'hA2});
    nop(1'b1);
    check("en_done", {31'h0, tx_valid}, 32'h0);
    for (int i = 0; i < 5; i++) store(8'hB0 + 8'(i), 1'b0);
    drive(A_ST, 32'h0, 4'h0, 1'b0);
    check("pre_flush_status", rdata, 32'h0000_0500);
    drive(A_CT, 32'h3, 4'h1, 1'b0);
    drive(A_ST, 32'h0, 4'h0, 1'b0);
    check("flush_status", rdata, 32'h0000_0002);
    check("flush_valid", {31'h0, tx_valid}, 32'h0);
    drive(A_CT, 32'h0, 4'h0, 1'b0);
    check("flush_ctrl", rdata, 32'h0000_0001);

    // Asynchronous reset mid-drain
    for (int i = 0; i < 4; i++) store(8'hC0 + 8'(i), 1'b0);
    nop(1'b1);
    check("pre_rst_c0", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'hC0});
    nop(1'b1);
    check("pre_rst_c1", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'hC1});
    rst = 1'b1;
    #1;
    check("rst_async_valid", {31'h0, tx_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(A_ST, 32'h0, 4'h0, 1'b0);
    check("post_rst_status", rdata, 32'h0000_0002);
    check("post_rst_status_p", rdata_p, 32'h0000_0002);
    drive(32'h2000_0000, 32'h0, 4'h0, 1'b0);
    check("miss_rdata", rdata, 32'h0);

    // Pacing with CHAR_CYCLES=3 on the second instance
    store(8'h31, 1'b0);
    store(8'h32, 1'b0);
    store(8'h33, 1'b0);
    nop(1'b0);
    tx_ready_p = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (tx_valid_p) begin
        fire_cyc.push_back(c);
        fire_dat.push_back(tx_data_p);
      end
      nop(1'b0);
    end
    tx_ready_p = 1'b0;
    check("pace_fire_count", fire_cyc.size(), 32'd3);
    for (int i = 0; i < fire_cyc.size() && i < 3; i++) begin
      check($sformatf("pace_cycle%0d", i), fire_cyc[i], 32'(4 * i));
      check($sformatf("pace_data%0d", i), {24'h0, fire_dat[i]}, {24'h0, 8'h31 + 8'(i)});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
